// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch : instruction-fetch stage.
//   Holds the PC, presents it to the combinational instruction ROM and
//   registers the returned word into the IF/ID pipeline register.
//   Handles stall, branch redirect (with a pending-redirect buffer used while
//   stalled) and exception flush.
//   Optional feature macro: DELAY_SLOT_EN
//     defined   - the word fetched in a redirect cycle is kept as a live
//                 delay-slot instruction.
//     undefined - that word is squashed into a bubble (default build).
// ----------------------------------------------------------------------------
module if_fetch #(
   parameter int                 ADDR_W   = 32,
   parameter int                 DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_inst,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_target,
   output logic [ADDR_W-1:0] id_pc,
   output logic [DATA_W-1:0] id_inst,
   output logic              id_valid,
   output logic              id_adel
);

`ifdef DELAY_SLOT_EN
   localparam bit DELAY_SLOT = 1'b1;
`else
   localparam bit DELAY_SLOT = 1'b0;
`endif

   logic [ADDR_W-1:0] pc;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_target;

   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] id_pc_nxt;
   logic [DATA_W-1:0] id_inst_nxt;
   logic              id_valid_nxt;
   logic              id_adel_nxt;
   logic              pend_valid_nxt;
   logic [ADDR_W-1:0] pend_target_nxt;
   logic              take_redirect;
   logic              misaligned;

   // The ROM is addressed directly by the PC; there is no enable.
   assign imem_addr  = pc;
   assign misaligned = (pc[1:0] != 2'b00);

   // Next-state selection: flush beats stall, stall beats any redirect,
   // a buffered redirect beats a live one, otherwise fetch sequentially.
   always_comb begin
      pc_nxt          = pc;
      id_pc_nxt       = id_pc;
      id_inst_nxt     = id_inst;
      id_valid_nxt    = id_valid;
      id_adel_nxt     = id_adel;
      pend_valid_nxt  = pend_valid;
      pend_target_nxt = pend_target;
      take_redirect   = 1'b0;

      if (flush) begin
         pc_nxt         = flush_target;
         id_valid_nxt   = 1'b0;
         id_inst_nxt    = '0;
         id_adel_nxt    = 1'b0;
         pend_valid_nxt = 1'b0;
      end else if (stall) begin
         if (redirect_valid) begin
            pend_target_nxt = redirect_target;
            pend_valid_nxt  = 1'b1;
         end
      end else begin
         id_pc_nxt    = pc;
         id_valid_nxt = 1'b1;
         if (misaligned) begin
            id_inst_nxt = '0;
            id_adel_nxt = 1'b1;
         end else begin
            id_inst_nxt = imem_inst;
            id_adel_nxt = 1'b0;
         end

         if (pend_valid) begin
            pc_nxt         = pend_target;
            pend_valid_nxt = 1'b0;
            take_redirect  = 1'b1;
         end else if (redirect_valid) begin
            pc_nxt        = redirect_target;
            take_redirect = 1'b1;
         end else begin
            pc_nxt = pc + ADDR_W'(4);
         end

         if (take_redirect && !DELAY_SLOT) begin
            id_valid_nxt = 1'b0;
            id_inst_nxt  = '0;
            id_adel_nxt  = 1'b0;
         end
      end
   end

   // State registers for the PC, the pending redirect and IF/ID.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= RESET_PC;
         pend_valid  <= 1'b0;
         pend_target <= '0;
         id_pc       <= '0;
         id_inst     <= '0;
         id_valid    <= 1'b0;
         id_adel     <= 1'b0;
      end else begin
         pc          <= pc_nxt;
         pend_valid  <= pend_valid_nxt;
         pend_target <= pend_target_nxt;
         id_pc       <= id_pc_nxt;
         id_inst     <= id_inst_nxt;
         id_valid    <= id_valid_nxt;
         id_adel     <= id_adel_nxt;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// ----------------------------------------------------------------------------
// tb_if_fetch : directed, scoreboard-checked bench for if_fetch.
//   The ROM model returns (word index + 1) for any address.
// ----------------------------------------------------------------------------
module tb_if_fetch;

`ifdef DELAY_SLOT_EN
   localparam logic DS = 1'b1;
`else
   localparam logic DS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        flush;
   logic [31:0] flush_target;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        id_adel;

   int testCount = 0;
   int failCount = 0;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        chk_id_pc;
      logic [31:0] id_pc;
      logic [31:0] id_inst;
      logic        id_valid;
      logic        id_adel;
   } exp_t;

   exp_t sbq[$];

   if_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_inst       (imem_inst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .flush           (flush),
      .flush_target    (flush_target),
      .id_pc           (id_pc),
      .id_inst         (id_inst),
      .id_valid        (id_valid),
      .id_adel         (id_adel)
   );

   always #5 clk = ~clk;

   assign imem_inst = (imem_addr >> 2) + 32'd1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      assert (got === exp) else begin
         failCount++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input string tag,
                                input logic st, input logic rv, input logic [31:0] rt,
                                input logic fl, input logic [31:0] ft,
                                input logic [31:0] e_pc, input logic chk_id_pc,
                                input logic [31:0] e_id_pc, input logic [31:0] e_inst,
                                input logic e_valid, input logic e_adel);
      exp_t e;
      exp_t g;
      @(negedge clk);
      stall           = st;
      redirect_valid  = rv;
      redirect_target = rt;
      flush           = fl;
      flush_target    = ft;
      e.tag = tag; e.pc = e_pc; e.chk_id_pc = chk_id_pc; e.id_pc = e_id_pc;
      e.id_inst = e_inst; e.id_valid = e_valid; e.id_adel = e_adel;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         testCount++;
         failCount++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         g = sbq.pop_front();
         checkOutput({g.tag, ".pc"},    imem_addr, g.pc);
         if (g.chk_id_pc) checkOutput({g.tag, ".id_pc"}, id_pc, g.id_pc);
         checkOutput({g.tag, ".inst"},  id_inst, g.id_inst);
         checkOutput({g.tag, ".valid"}, {31'd0, id_valid}, {31'd0, g.id_valid});
         checkOutput({g.tag, ".adel"},  {31'd0, id_adel},  {31'd0, g.id_adel});
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, ".pc"},    imem_addr, 32'h0);
      checkOutput({tag, ".id_pc"}, id_pc, 32'h0);
      checkOutput({tag, ".inst"},  id_inst, 32'h0);
      checkOutput({tag, ".valid"}, {31'd0, id_valid}, 32'd0);
      checkOutput({tag, ".adel"},  {31'd0, id_adel},  32'd0);
   endtask

   // Safety net so the run always ends.
   initial begin
      #100000;
      failCount++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      flush = 1'b0; flush_target = '0;
      #3;
      checkReset("reset");
      #5 rst = 1'b1;

      // Sequential fetch
      applyStimulus("seq0", 0,0,0, 0,0, 32'h4,  1, 32'h0,  32'h1, 1, 0);
      applyStimulus("seq1", 0,0,0, 0,0, 32'h8,  1, 32'h4,  32'h2, 1, 0);
      applyStimulus("seq2", 0,0,0, 0,0, 32'hC,  1, 32'h8,  32'h3, 1, 0);
      applyStimulus("seq3", 0,0,0, 0,0, 32'h10, 1, 32'hC,  32'h4, 1, 0);

      // Redirect at pc=0x10 to 0x40
      applyStimulus("br",   0,1,32'h40, 0,0, 32'h40, 1, 32'h10, DS ? 32'h5 : 32'h0, DS, 0);
      applyStimulus("br1",  0,0,0, 0,0, 32'h44, 1, 32'h40, 32'h11, 1, 0);
      applyStimulus("br2",  0,0,0, 0,0, 32'h48, 1, 32'h44, 32'h12, 1, 0);

      // Stall with a buffered redirect (second one overwrites the first)
      applyStimulus("st0",  1,0,0,       0,0, 32'h48, 1, 32'h44, 32'h12, 1, 0);
      applyStimulus("st1",  1,1,32'h70,  0,0, 32'h48, 1, 32'h44, 32'h12, 1, 0);
      applyStimulus("st2",  1,1,32'h80,  0,0, 32'h48, 1, 32'h44, 32'h12, 1, 0);
      // Live redirect on release is ignored in favour of the buffered one
      applyStimulus("rel",  0,1,32'h500, 0,0, 32'h80, 1, 32'h48, DS ? 32'h13 : 32'h0, DS, 0);
      applyStimulus("rel1", 0,0,0,       0,0, 32'h84, 1, 32'h80, 32'h21, 1, 0);

      // Flush beats stall and redirect
      applyStimulus("fl",   1,1,32'h100, 1,32'h180, 32'h180, 0, 32'h0, 32'h0, 0, 0);
      applyStimulus("fl1",  0,0,0, 0,0, 32'h184, 1, 32'h180, 32'h61, 1, 0);
      applyStimulus("fl2",  0,0,0, 0,0, 32'h188, 1, 32'h184, 32'h62, 1, 0);

      // Misaligned redirect target
      applyStimulus("ma",   0,1,32'h42, 0,0, 32'h42, 1, 32'h188, DS ? 32'h63 : 32'h0, DS, 0);
      applyStimulus("ma1",  0,0,0, 0,0, 32'h46, 1, 32'h42, 32'h0, 1, 1);
      applyStimulus("ma2",  0,0,0, 0,0, 32'h4A, 1, 32'h46, 32'h0, 1, 1);
      applyStimulus("ma3",  0,1,32'h200, 0,0, 32'h200, 1, 32'h4A, 32'h0, DS, DS);
      applyStimulus("ma4",  0,0,0, 0,0, 32'h204, 1, 32'h200, 32'h81, 1, 0);

      // Reset mid-run while stalled with a pending redirect
      applyStimulus("pr",   1,1,32'h300, 0,0, 32'h204, 1, 32'h200, 32'h81, 1, 0);
      #2 rst = 1'b0;
      #1;
      checkReset("midrst");
      rst = 1'b1;
      applyStimulus("rs0",  0,0,0, 0,0, 32'h4, 1, 32'h0, 32'h1, 1, 0);
      applyStimulus("rs1",  0,0,0, 0,0, 32'h8, 1, 32'h4, 32'h2, 1, 0);

      // PC wrap at the top of the address space
      applyStimulus("wr",   0,0,0, 1,32'hFFFFFFFC, 32'hFFFFFFFC, 0, 32'h0, 32'h0, 0, 0);
      applyStimulus("wr1",  0,0,0, 0,0, 32'h0, 1, 32'hFFFFFFFC, 32'h40000000, 1, 0);
      applyStimulus("wr2",  0,0,0, 0,0, 32'h4, 1, 32'h0, 32'h1, 1, 0);

      @(negedge clk);
      stall = 1'b0; redirect_valid = 1'b0; flush = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
